// File: rtl/audio_serializer_fifo.sv
// Buffered audio serializer: a small FIFO of parallel sample words shifted out on audio_data,
// each bit held BIT_CYCLES clocks. Optional macro REPEAT_LAST_EN replays the last word on underrun.
module audio_serializer_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int BIT_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  lsb_first,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  done,
    output logic                  underrun,
    output logic                  audio_data,
    output logic                  audio_enable
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(BIT_CYCLES < 2 ? 2 : BIT_CYCLES);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] head;
    logic                  full, empty, push, pop;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  lsb_q, lsb_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  audio_q, audio_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic                  audio_en_q;

    // Position idx in transmission order, mapped onto the word according to bit order.
    function automatic logic sel_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb,
                                     input logic [BIT_W-1:0] idx);
        logic [BIT_W-1:0] msb_idx;
        msb_idx = BIT_LAST - idx;
        return lsb ? w[idx] : w[msb_idx];
    endfunction

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = data_valid & ~full;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        lsb_d      = lsb_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        audio_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    lsb_d     = lsb_first;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    audio_d   = sel_bit(head, lsb_first, '0);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (div_cnt_q != DIV_LAST) begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                    audio_d   = audio_q;
                end else if (bit_cnt_q != BIT_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    audio_d   = sel_bit(shreg_q, lsb_q, bit_cnt_q + BIT_ONE);
                end else begin
                    // Word boundary: chain straight into the next word when one is queued.
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        lsb_d   = lsb_first;
                        audio_d = sel_bit(head, lsb_first, '0);
                    end else begin
                        underrun_d = 1'b1;
`ifdef REPEAT_LAST_EN
                        audio_d = sel_bit(shreg_q, lsb_q, '0);
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lsb_q      <= 1'b0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            audio_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            audio_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lsb_q      <= lsb_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            audio_q    <= audio_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            audio_en_q <= enable;
        end
    end

    assign data_ready   = ~full;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign audio_data   = audio_q;
    assign audio_enable = audio_en_q;

endmodule

// File: tb/tb_audio_serializer_fifo.sv
// Directed bench for audio_serializer_fifo (16-bit words, 4 clocks per bit, 4-deep FIFO).
module tb_audio_serializer_fifo;

    logic        clock = 1'b0;
    logic        reset_n, enable, lsb_first, data_valid;
    logic [15:0] data_in;
    logic        data_ready, done, underrun, audio_data, audio_enable;

    int n_checks = 0;
    int n_pass   = 0;
    logic aud [0:299];
    logic dn  [0:299];
    logic ur  [0:299];
    logic [63:0] tv;
    logic [15:0] w4 [0:4];

    always #5 clock = ~clock;

    audio_serializer_fifo #(.DATA_WIDTH(16), .BIT_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .lsb_first(lsb_first),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .done(done), .underrun(underrun), .audio_data(audio_data), .audio_enable(audio_enable)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sample(input int i);
        aud[i] = audio_data;
        dn[i]  = done;
        ur[i]  = underrun;
    endtask

    // Record outputs at each of the next n falling edges into indices start..start+n-1.
    task automatic capture(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            @(negedge clock);
            sample(i);
        end
    endtask

    task automatic push1(input logic [15:0] w);
        data_in    = w;
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    function automatic logic [63:0] trace64(input int start);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63-i] = aud[start+i];
        return v;
    endfunction

    function automatic int count_set(input int which, input int a, input int b);
        int c;
        c = 0;
        for (int i = a; i <= b; i++)
            c += (which == 0) ? int'(aud[i]) : (which == 1) ? int'(dn[i]) : int'(ur[i]);
        return c;
    endfunction

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; lsb_first = 1'b0; data_valid = 1'b0; data_in = '0;
        repeat (3) @(negedge clock);
        check("rst_audio", audio_data, 0);
        check("rst_aen", audio_enable, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        enable  = 1'b0;
        @(negedge clock);
        check("rel_ready", data_ready, 1);
        check("rel_audio", audio_data, 0);

`ifndef REPEAT_LAST_EN
        // Single word, MSB first, ends in underrun and idle.
        enable = 1'b1;
        push1(16'h8001);
        check("t2_latency", audio_data, 0);
        check("t2_aen", audio_enable, 1);
        capture(0, 70);
        check("t2_trace", trace64(0), 64'hF000_0000_0000_000F);
        check("t2_done64", dn[64], 1);
        check("t2_done_cnt", 64'(count_set(1, 0, 69)), 1);
        check("t2_ur64", ur[64], 1);
        check("t2_tail", 64'(count_set(0, 64, 69)), 0);

        // Back-to-back words stream with no gap.
        data_in = 16'h8001; data_valid = 1'b1;
        @(negedge clock);
        data_in = 16'hC000;
        @(negedge clock);
        data_valid = 1'b0;
        sample(0);
        capture(1, 131);
        check("t3_w1", trace64(0), 64'hF000_0000_0000_000F);
        check("t3_w2", trace64(64), 64'hFF00_0000_0000_0000);
        check("t3_done64", dn[64], 1);
        check("t3_ur64", ur[64], 0);
        check("t3_done_cnt", 64'(count_set(1, 0, 131)), 2);
        check("t3_ur128", ur[128], 1);
        check("t3_idle", aud[130], 0);

        // Fill while disabled; fifth push refused.
        enable = 1'b0;
        w4[0] = 16'h8000; w4[1] = 16'h0001; w4[2] = 16'hFFFF; w4[3] = 16'h0000; w4[4] = 16'hAAAA;
        data_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = w4[k];
            @(negedge clock);
            check($sformatf("t4_ready%0d", k), data_ready, (k < 3) ? 64'd1 : 64'd0);
        end
        data_valid = 1'b0;
        check("t4_held", audio_data, 0);
        enable = 1'b1;
        capture(0, 262);
        check("t4_w0", trace64(0), 64'hF000_0000_0000_0000);
        check("t4_w1", trace64(64), 64'h0000_0000_0000_000F);
        check("t4_w2", trace64(128), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_w3", trace64(192), 64'h0);
        check("t4_done_cnt", 64'(count_set(1, 0, 261)), 4);
        check("t4_ur256", ur[256], 1);
        check("t4_no5th", 64'(count_set(0, 256, 261)), 0);
        check("t4_ready_end", data_ready, 1);

        // LSB-first word, then abort mid-word.
        lsb_first = 1'b1;
        push1(16'h0003);
        capture(0, 20);
        tv = trace64(0);
        check("t5_head", tv[63:44], 20'hFF000);
        enable = 1'b0;
        capture(20, 70);
        check("t5_abort", aud[20], 0);
        check("t5_abort_hi", 64'(count_set(0, 20, 89)), 0);
        check("t5_no_done", 64'(count_set(1, 20, 89)), 0);
        check("t5_no_ur", 64'(count_set(2, 20, 89)), 0);
        check("t5_aen_off", audio_enable, 0);

        // Push accepted while disabled, streams once enabled.
        lsb_first = 1'b0;
        push1(16'h4000);
        check("t5_ready_dis", data_ready, 1);
        check("t5_still_idle", audio_data, 0);
        enable = 1'b1;
        capture(0, 70);
        check("t5_resume", trace64(0), 64'h0F00_0000_0000_0000);
        check("t5_resume_ur", ur[64], 1);
`else
        // Underrun replays the last word continuously.
        enable = 1'b1;
        push1(16'hA5A5);
        capture(0, 200);
        check("t6_w0", trace64(0), 64'hF0F0_0F0F_F0F0_0F0F);
        check("t6_w1", trace64(64), 64'hF0F0_0F0F_F0F0_0F0F);
        check("t6_w2", trace64(128), 64'hF0F0_0F0F_F0F0_0F0F);
        check("t6_ur64", ur[64], 1);
        check("t6_ur128", ur[128], 1);
        check("t6_done_cnt", 64'(count_set(1, 0, 199)), 3);
        check("t6_ur_cnt", 64'(count_set(2, 0, 199)), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
